// File: rtl/draw_scheduler.sv
// draw_scheduler: shares one rectangle draw datapath between NUM_OBJ object slots.
// Each frame erases prior positions in BG_COLOUR, then draws new ones. Optional watchdog: DRAW_SCHED_WATCHDOG_EN.
module draw_scheduler #(
  parameter int unsigned NUM_OBJ   = 4,
  parameter int unsigned IDX_W     = 2,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic [NUM_OBJ-1:0]   obj_valid,
  input  logic [8*NUM_OBJ-1:0] obj_x,
  input  logic [7*NUM_OBJ-1:0] obj_y,
  input  logic [5*NUM_OBJ-1:0] obj_w,
  input  logic [5*NUM_OBJ-1:0] obj_h,
  input  logic [3*NUM_OBJ-1:0] obj_c,
  input  logic                 draw_done,
  output logic                 draw_en,
  output logic [7:0]           draw_x,
  output logic [6:0]           draw_y,
  output logic [4:0]           draw_w,
  output logic [4:0]           draw_h,
  output logic [2:0]           draw_c,
  output logic                 plot,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_overrun,
  output logic [IDX_W-1:0]     cur_idx,
  output logic                 draw_timeout
);

  typedef enum logic [2:0] {IDLE, SELECT, LOAD, RUN, GAP, FIN} state_t;
  typedef enum logic {ERASE, DRAW} phase_t;

  state_t                  state_q;
  phase_t                  phase_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_OBJ-1:0]      snap_valid_q, prev_valid_q;
  logic [NUM_OBJ-1:0][7:0] snap_x_q, prev_x_q;
  logic [NUM_OBJ-1:0][6:0] snap_y_q, prev_y_q;
  logic [NUM_OBJ-1:0][4:0] snap_w_q, prev_w_q;
  logic [NUM_OBJ-1:0][4:0] snap_h_q, prev_h_q;
  logic [NUM_OBJ-1:0][2:0] snap_c_q;
  logic [7:0]              draw_x_q;
  logic [6:0]              draw_y_q;
  logic [4:0]              draw_w_q, draw_h_q;
  logic [2:0]              draw_c_q;
  logic                    overrun_q;

  logic       cand_v, cand_ok;
  logic [7:0] cand_x;
  logic [6:0] cand_y;
  logic [4:0] cand_w, cand_h;
  logic [2:0] cand_c;

  state_t           adv_state;
  phase_t           adv_phase;
  logic [IDX_W-1:0] adv_idx;

`ifdef DRAW_SCHED_WATCHDOG_EN
  localparam logic [10:0] WDOG_LAST = 11'd1099;
  logic [10:0] wdog_q;
  logic        timeout_q;
  assign draw_timeout = timeout_q;
`else
  assign draw_timeout = 1'b0;
`endif

  always_comb begin
    if (phase_q == ERASE) begin
      cand_v = prev_valid_q[idx_q];
      cand_x = prev_x_q[idx_q];
      cand_y = prev_y_q[idx_q];
      cand_w = prev_w_q[idx_q];
      cand_h = prev_h_q[idx_q];
      cand_c = BG_COLOUR;
    end else begin
      cand_v = snap_valid_q[idx_q];
      cand_x = snap_x_q[idx_q];
      cand_y = snap_y_q[idx_q];
      cand_w = snap_w_q[idx_q];
      cand_h = snap_h_q[idx_q];
      cand_c = snap_c_q[idx_q];
    end
    cand_ok = cand_v && (cand_w != '0) && (cand_h != '0);
  end

  always_comb begin
    adv_state = SELECT;
    adv_phase = phase_q;
    adv_idx   = idx_q + 1'b1;
    if (idx_q == IDX_W'(NUM_OBJ - 1)) begin
      if (phase_q == ERASE) begin
        adv_phase = DRAW;
        adv_idx   = '0;
      end else begin
        adv_state = FIN;
        adv_idx   = idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      phase_q      <= ERASE;
      idx_q        <= '0;
      snap_valid_q <= '0;
      prev_valid_q <= '0;
      snap_x_q     <= '0;
      snap_y_q     <= '0;
      snap_w_q     <= '0;
      snap_h_q     <= '0;
      snap_c_q     <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_w_q     <= '0;
      prev_h_q     <= '0;
      draw_x_q     <= '0;
      draw_y_q     <= '0;
      draw_w_q     <= '0;
      draw_h_q     <= '0;
      draw_c_q     <= '0;
      overrun_q    <= 1'b0;
`ifdef DRAW_SCHED_WATCHDOG_EN
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      if (frame_start && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (frame_start) begin
          snap_valid_q <= obj_valid;
          snap_x_q     <= obj_x;
          snap_y_q     <= obj_y;
          snap_w_q     <= obj_w;
          snap_h_q     <= obj_h;
          snap_c_q     <= obj_c;
          phase_q      <= ERASE;
          idx_q        <= '0;
          state_q      <= SELECT;
        end
        SELECT: if (cand_ok) begin
          draw_x_q <= cand_x;
          draw_y_q <= cand_y;
          draw_w_q <= cand_w;
          draw_h_q <= cand_h;
          draw_c_q <= cand_c;
          state_q  <= LOAD;
        end else begin
          // An empty draw slot also forgets the old object so it is not erased again.
          if (phase_q == DRAW) prev_valid_q[idx_q] <= 1'b0;
          state_q <= adv_state;
          phase_q <= adv_phase;
          idx_q   <= adv_idx;
        end
        LOAD: begin
`ifdef DRAW_SCHED_WATCHDOG_EN
          wdog_q  <= '0;
`endif
          state_q <= RUN;
        end
        RUN: if (draw_done) begin
          if (phase_q == DRAW) begin
            prev_valid_q[idx_q] <= 1'b1;
            prev_x_q[idx_q]     <= snap_x_q[idx_q];
            prev_y_q[idx_q]     <= snap_y_q[idx_q];
            prev_w_q[idx_q]     <= snap_w_q[idx_q];
            prev_h_q[idx_q]     <= snap_h_q[idx_q];
          end
          state_q <= GAP;
        end
`ifdef DRAW_SCHED_WATCHDOG_EN
        else if (wdog_q == WDOG_LAST) begin
          timeout_q <= 1'b1;
          state_q   <= GAP;
        end else begin
          wdog_q <= wdog_q + 11'd1;
        end
`endif
        GAP: begin
          state_q <= adv_state;
          phase_q <= adv_phase;
          idx_q   <= adv_idx;
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign draw_en       = (state_q == LOAD) || (state_q == RUN);
  assign plot          = (state_q == RUN) && !draw_done;
  assign busy          = (state_q != IDLE);
  assign frame_done    = (state_q == FIN);
  assign frame_overrun = overrun_q;
  assign cur_idx       = idx_q;
  assign draw_x        = draw_x_q;
  assign draw_y        = draw_y_q;
  assign draw_w        = draw_w_q;
  assign draw_h        = draw_h_q;
  assign draw_c        = draw_c_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: datapath stand-in plus a frame-level job model (erase list then draw list).
module tb_draw_scheduler;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           frame_start = 1'b0;
  logic [N-1:0]   obj_valid = '0;
  logic [8*N-1:0] obj_x = '0;
  logic [7*N-1:0] obj_y = '0;
  logic [5*N-1:0] obj_w = '0;
  logic [5*N-1:0] obj_h = '0;
  logic [3*N-1:0] obj_c = '0;
  logic           draw_done;
  logic           draw_en, plot, busy, frame_done, frame_overrun, draw_timeout;
  logic [7:0]     draw_x;
  logic [6:0]     draw_y;
  logic [4:0]     draw_w, draw_h;
  logic [2:0]     draw_c;
  logic [1:0]     cur_idx;

  draw_scheduler #(.NUM_OBJ(N), .IDX_W(2), .BG_COLOUR(3'b000)) dut (
    .clk(clk), .reset(rst_n), .frame_start(frame_start), .obj_valid(obj_valid),
    .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h), .obj_c(obj_c),
    .draw_done(draw_done), .draw_en(draw_en), .draw_x(draw_x), .draw_y(draw_y),
    .draw_w(draw_w), .draw_h(draw_h), .draw_c(draw_c), .plot(plot), .busy(busy),
    .frame_done(frame_done), .frame_overrun(frame_overrun), .cur_idx(cur_idx),
    .draw_timeout(draw_timeout)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: latches size on the first enable cycle, one pixel per cycle, sticky done.
  logic dp_active = 1'b0;
  int   dp_cnt = 0, dp_total = 0;
  bit   stall = 1'b0;
  always @(posedge clk) begin
    if (!draw_en) begin
      dp_active <= 1'b0;
      dp_cnt    <= 0;
    end else if (!dp_active) begin
      dp_active <= 1'b1;
      dp_cnt    <= 0;
      dp_total  <= int'(draw_w) * int'(draw_h);
    end else if (dp_cnt < dp_total) begin
      dp_cnt <= dp_cnt + 1;
    end
  end
  assign draw_done = dp_active && (dp_cnt == dp_total) && !stall;

  typedef struct {
    logic [7:0] x; logic [6:0] y; logic [4:0] w; logic [4:0] h; logic [2:0] c; logic [1:0] idx;
  } job_t;

  job_t       pixq[$];
  bit         mprev_v[N];
  logic [7:0] mprev_x[N];
  logic [6:0] mprev_y[N];
  logic [4:0] mprev_w[N], mprev_h[N];
  int exp_len, exp_en, exp_plots;

  int checks = 0, errors = 0;
  int plot_cnt, en_cnt, busy_cnt, fd_cnt;
  logic [7:0] first_x, last_x;
  logic [6:0] first_y;
  logic [2:0] first_c, last_c;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    job_t e;
    if (rst_n && !stall) begin
      if (plot) begin
        if (plot_cnt == 0) begin first_x = draw_x; first_y = draw_y; first_c = draw_c; end
        last_x = draw_x; last_c = draw_c;
        plot_cnt++;
        checks++;
        if (pixq.size() == 0) begin
          errors++;
          $display("FAIL plot_unexpected: got plot=1 x=%0d c=%0d expected plot=0", draw_x, draw_c);
        end else begin
          e = pixq.pop_front();
          if (draw_x !== e.x || draw_y !== e.y || draw_w !== e.w || draw_h !== e.h ||
              draw_c !== e.c || cur_idx !== e.idx) begin
            errors++;
            $display("FAIL plot_params: got x=%0d y=%0d w=%0d h=%0d c=%0d idx=%0d expected x=%0d y=%0d w=%0d h=%0d c=%0d idx=%0d",
                     draw_x, draw_y, draw_w, draw_h, draw_c, cur_idx, e.x, e.y, e.w, e.h, e.c, e.idx);
          end
        end
      end
      if (draw_en)    en_cnt++;
      if (busy)       busy_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic push_job(input job_t j);
    int n = int'(j.w) * int'(j.h);
    for (int k = 0; k < n; k++) pixq.push_back(j);
    exp_len   += n + 4;
    exp_en    += n + 2;
    exp_plots += n;
  endtask

  // Frame model: an erase job per remembered object, then a draw job per non-empty valid object.
  task automatic build_model();
    job_t j;
    exp_len = 1; exp_en = 0; exp_plots = 0;
    pixq.delete();
    for (int i = 0; i < N; i++) begin
      if (mprev_v[i]) begin
        j.x = mprev_x[i]; j.y = mprev_y[i]; j.w = mprev_w[i]; j.h = mprev_h[i];
        j.c = 3'b000; j.idx = 2'(i);
        push_job(j);
      end else exp_len += 1;
    end
    for (int i = 0; i < N; i++) begin
      j.x = obj_x[8*i +: 8]; j.y = obj_y[7*i +: 7]; j.w = obj_w[5*i +: 5];
      j.h = obj_h[5*i +: 5]; j.c = obj_c[3*i +: 3]; j.idx = 2'(i);
      if (obj_valid[i] && j.w != 0 && j.h != 0) begin
        push_job(j);
        mprev_v[i] = 1'b1; mprev_x[i] = j.x; mprev_y[i] = j.y; mprev_w[i] = j.w; mprev_h[i] = j.h;
      end else begin
        mprev_v[i] = 1'b0;
        exp_len += 1;
      end
    end
  endtask

  task automatic set_obj(input int i, input bit v, input logic [7:0] x, input logic [6:0] y,
                         input logic [4:0] w, input logic [4:0] h, input logic [2:0] c);
    obj_valid[i] = v; obj_x[8*i +: 8] = x; obj_y[7*i +: 7] = y;
    obj_w[5*i +: 5] = w; obj_h[5*i +: 5] = h; obj_c[3*i +: 3] = c;
  endtask

  task automatic clear_objs();
    for (int i = 0; i < N; i++) set_obj(i, 1'b0, 8'd0, 7'd0, 5'd0, 5'd0, 3'd0);
  endtask

  task automatic rand_objs();
    for (int i = 0; i < N; i++)
      set_obj(i, 1'($urandom_range(0, 1)), 8'($urandom), 7'($urandom), 5'($urandom_range(0, 4)),
              5'($urandom_range(0, 4)), 3'($urandom));
  endtask

  task automatic start_frame();
    plot_cnt = 0; en_cnt = 0; busy_cnt = 0; fd_cnt = 0;
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic run_frame(input bit ovr);
    bit got = 1'b0;
    build_model();
    start_frame();
    for (int c = 0; c < exp_len + 50 && !got; c++) begin
      @(negedge clk);
      frame_start = ovr && (c == 3);
      if (frame_done) got = 1'b1;
    end
    frame_start = 1'b0;
    chk("frame_done_seen", int'(got), 1);
    @(negedge clk);
    chk("frame_len", busy_cnt, exp_len);
    chk("en_cycles", en_cnt, exp_en);
    chk("plot_cycles", plot_cnt, exp_plots);
    chk("pixels_left", pixq.size(), 0);
    chk("frame_done_pulses", fd_cnt, 1);
    chk("busy_after", int'(busy), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_draw_en"}, int'(draw_en), 0);
    chk({tag, "_plot"}, int'(plot), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_overrun"}, int'(frame_overrun), 0);
    chk({tag, "_cur_idx"}, int'(cur_idx), 0);
    chk({tag, "_draw_params"}, int'({draw_x, draw_y, draw_w, draw_h, draw_c}), 0);
    chk({tag, "_timeout"}, int'(draw_timeout), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pixq.delete();
    for (int i = 0; i < N; i++) mprev_v[i] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < N; i++) mprev_v[i] = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // First frame: one object, nothing to erase.
    clear_objs();
    set_obj(0, 1'b1, 8'd10, 7'd5, 5'd2, 5'd3, 3'b100);
    run_frame(1'b0);
    chk("f1_len_literal", busy_cnt, 18);
    chk("f1_plots_literal", plot_cnt, 6);
    chk("f1_x", int'(first_x), 10);
    chk("f1_y", int'(first_y), 5);
    chk("f1_c", int'(first_c), 4);

    // Move: erase at old x in background, then draw at new x.
    set_obj(0, 1'b1, 8'd12, 7'd5, 5'd2, 5'd3, 3'b100);
    run_frame(1'b0);
    chk("f2_len_literal", busy_cnt, 27);
    chk("f2_plots_literal", plot_cnt, 12);
    chk("f2_erase_x", int'(first_x), 10);
    chk("f2_erase_c", int'(first_c), 0);
    chk("f2_draw_x", int'(last_x), 12);
    chk("f2_draw_c", int'(last_c), 4);

    // Zero-width slot is never drawn nor remembered.
    set_obj(1, 1'b1, 8'd40, 7'd20, 5'd0, 5'd3, 3'b010);
    run_frame(1'b0);
    chk("zero_w_en_literal", en_cnt, 16);
    clear_objs();
    run_frame(1'b0);
    chk("erase_only_en_literal", en_cnt, 8);

    for (int f = 0; f < 15; f++) begin
      rand_objs();
      run_frame(1'b0);
    end

    // Overrun during a frame leaves it intact and sticks.
    rand_objs();
    set_obj(0, 1'b1, 8'd3, 7'd3, 5'd3, 5'd3, 3'b111);
    run_frame(1'b1);
    chk("overrun_set", int'(frame_overrun), 1);
    rand_objs();
    run_frame(1'b0);
    chk("overrun_sticky", int'(frame_overrun), 1);

    // Reset in the middle of a draw.
    clear_objs();
    set_obj(2, 1'b1, 8'd50, 7'd60, 5'd4, 5'd4, 3'b011);
    build_model();
    start_frame();
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (plot) seen = 1'b1;
    end
    chk("mid_plot_seen", int'(seen), 1);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    pixq.delete();
    for (int i = 0; i < N; i++) mprev_v[i] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rand_objs();
    run_frame(1'b0);
    chk("post_reset_overrun", int'(frame_overrun), 0);

    // Datapath that never finishes.
    clear_objs();
    set_obj(0, 1'b1, 8'd1, 7'd1, 5'd2, 5'd2, 3'b001);
    stall = 1'b1;
    start_frame();
`ifdef DRAW_SCHED_WATCHDOG_EN
    seen = 1'b0;
    for (int c = 0; c < 1400 && !seen; c++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk("wdog_frame_done", int'(seen), 1);
    chk("wdog_timeout", int'(draw_timeout), 1);
`else
    repeat (1200) @(negedge clk);
    chk("stall_busy", int'(busy), 1);
    chk("stall_draw_en", int'(draw_en), 1);
    chk("stall_cur_idx", int'(cur_idx), 0);
    chk("stall_timeout", int'(draw_timeout), 0);
`endif
    stall = 1'b0;
    do_reset();
    rand_objs();
    run_frame(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
